// File: rtl/cla_bist_controller.sv
// BIST controller for the registered CLA adder: sweeps every {cin, b, a} vector and checks sum/cout.
// Latency: 2^(2*WIDTH+1) RUN cycles plus LATENCY drain cycles from start to done.
// Backpressure: none; start is ignored while busy, and results hold in DONE until the next start.
module cla_bist_controller #(
    parameter int WIDTH   = 4,
    parameter int LATENCY = 2,
    parameter int ERR_W   = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     dut_a,
    output logic [WIDTH-1:0]     dut_b,
    output logic                 dut_cin,
    input  logic [WIDTH-1:0]     dut_sum,
    input  logic                 dut_cout,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     err_count,
    output logic [2*WIDTH:0]     first_fail_vec,
    output logic                 first_fail_valid
);

    localparam int VW = 2 * WIDTH + 1;
    localparam int DW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(LATENCY - 1);
    localparam logic [VW-1:0] VEC_MAX    = '1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]          state;
    logic [VW-1:0]       vec;
    logic [DW-1:0]       drain_cnt;
    logic [LATENCY-1:0]  vld_pipe;
    logic [VW-1:0]       idx_pipe [LATENCY];
    logic [VW-1:0]       chk_idx;
    logic [WIDTH:0]      exp_res;
    logic                mismatch;
    logic                start_ok;

    // The vector register is the drive flop itself, so dut_* never see a combinational input path.
    assign dut_a   = vec[WIDTH-1:0];
    assign dut_b   = vec[2*WIDTH-1:WIDTH];
    assign dut_cin = vec[2*WIDTH];

    assign busy     = (state == S_RUN) || (state == S_DRAIN);
    assign done     = (state == S_DONE);
    assign pass     = done && (err_count == '0);
    assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            vec       <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state <= S_RUN;
                        vec   <= '0;
                    end
                end
                S_RUN: begin
                    if (vec == VEC_MAX) begin
                        state     <= S_DRAIN;
                        vec       <= '0;
                        drain_cnt <= '0;
                    end else begin
                        vec <= vec + VW'(1);
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= S_DONE;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Delay line tracks which driven vector the adder output currently belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            for (int i = 0; i < LATENCY; i++) idx_pipe[i] <= '0;
        end else begin
            vld_pipe[0] <= (state == S_RUN);
            idx_pipe[0] <= vec;
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                idx_pipe[i] <= idx_pipe[i-1];
            end
        end
    end

    always_comb begin
        chk_idx  = idx_pipe[LATENCY-1];
        exp_res  = {1'b0, chk_idx[WIDTH-1:0]}
                 + {1'b0, chk_idx[2*WIDTH-1:WIDTH]}
                 + {{WIDTH{1'b0}}, chk_idx[2*WIDTH]};
        mismatch = vld_pipe[LATENCY-1] && ({dut_cout, dut_sum} != exp_res);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else if (start_ok) begin
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else if (mismatch) begin
            if (err_count != '1) err_count <= err_count + ERR_W'(1);
            if (!first_fail_valid) begin
                first_fail_vec   <= chk_idx;
                first_fail_valid <= 1'b1;
            end
        end
    end

endmodule

// File: doc/cla_bist_controller.md
Name: cla_bist_controller

Overview:
Built-in self-test controller for the registered 4-bit CLA adder datapath (input flops, CLA, output flops; 2-cycle latency).
- Drives every {cin, b, a} combination into the adder.
- Samples sum/cout after the pipeline latency and compares them against an internally computed reference.
- Reports pass/fail, a saturating error count and the first failing vector.
- Sits beside the adder at the top level, on the opposite side of the adder's a/b/cin/sum/cout interface.

Parameters:
- WIDTH, 4, operand width; vector space is 2^(2*WIDTH+1) (512 at default).
- LATENCY, 2, clock edges from adder input pins to registered sum/cout.
- ERR_W, 10, width of err_count; saturates at all-ones.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin a test; honoured in IDLE and DONE only.
- dut_a  out  WIDTH  operand a to adder.
- dut_b  out  WIDTH  operand b to adder.
- dut_cin  out  1  carry-in to adder.
- dut_sum  in  WIDTH  registered sum from adder.
- dut_cout  in  1  registered carry-out from adder.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE.
- pass  out  1  done && err_count==0.
- err_count  out  ERR_W  number of mismatching vectors, saturating.
- first_fail_vec  out  2*WIDTH+1  index of first mismatching vector.
- first_fail_valid  out  1  first_fail_vec holds a captured index.

Behaviour:
- Reset (rst_n low, async): state IDLE; all outputs 0; vector counter, valid pipe, err_count, first_fail_* cleared. Reset mid-test aborts immediately. No partial result is retained.
- Vector index v = {cin, b, a}; a in LSBs. Drive outputs are registered from v; there is no combinational path from inputs to dut_*.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: dut_* = 0. On start -> RUN; clear err_count, first_fail_*, v=0.
  - RUN: each cycle drive v, then v+1. After driving v = max (all ones) -> DRAIN. Counter does not wrap into a second pass.
  - DRAIN: exactly LATENCY cycles; dut_* hold 0. Then -> DONE.
  - DONE: done=1; results held stable. start -> RUN with results cleared as in IDLE.
- start in RUN/DRAIN: ignored, no effect.
- Compare timing: the vector driven in RUN cycle n is checked at the edge ending cycle n+LATENCY. Use a valid/index delay line of depth LATENCY.
  - No compare while the delay-line valid bit is 0, so unreset X on the adder flops after power-up is never checked.
  - Exactly 2^(2*WIDTH+1) compares per test.
- Reference: {exp_cout, exp_sum} = a + b + cin, computed at WIDTH+1 bits from the delayed index. Mismatch = either field differs.
- On mismatch: err_count += 1 unless all-ones (saturate). If first_fail_valid==0, capture the index and set first_fail_valid.
- Timing at defaults, start sampled at edge E:
  - busy rises after E and falls after E+514.
  - done rises at E+514.
  - The final compare occurs at E+514, and its result is visible in err_count/pass with done.

Test Plan:
- Reset, start pulse, correct adder -> busy 514 cycles; done at start edge+514; pass=1, err_count=0, first_fail_valid=0.
- Adder model with sum[2] stuck-at-0 -> err_count=256, first_fail_vec=9'h004, first_fail_valid=1, pass=0.
- Adder model with cout stuck-at-0 -> err_count=256, first_fail_vec=9'h01F, pass=0.
- ERR_W=3, sum[0] stuck-at-1 -> err_count saturates at 3'h7, first_fail_vec=9'h000, pass=0.
- rst_n low during RUN cycle 100 -> all outputs 0 in the same cycle, state IDLE. Following start with a correct adder -> pass=1 after 514 cycles.
- start pulsed in RUN cycle 50 -> ignored, done still at edge+514. start in DONE after a failing run -> done drops, err_count cleared, new run with a correct adder gives pass=1.
